// File: rtl/cache_pkg.sv
// Shared types and derived-width helpers for the direct-mapped cache.
// CACHE_STATS_EN (optional) adds hit/miss counters to dm_cache_ctrl.
package cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        WB,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    function automatic int calc_off(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    function automatic int calc_idx(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int calc_tag(input int aw, input int lines, input int line_words);
        return aw - calc_idx(lines) - calc_off(line_words);
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Data/tag/valid/dirty arrays: combinational read of one line,
// whole-line refill write and strobed single-word write.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int LINES      = 256,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 20
) (
    input  logic                                  clk,
    input  logic                                  rst_b,
    input  logic [calc_idx(LINES)-1:0]            idx,
    output logic [TAG_W-1:0]                      tag_out,
    output logic [32*LINE_WORDS-1:0]              line_out,
    output logic                                  valid_out,
    output logic                                  dirty_out,
    input  logic                                  fill_we,
    input  logic [TAG_W-1:0]                      fill_tag,
    input  logic [32*LINE_WORDS-1:0]              fill_data,
    input  logic                                  word_we,
    input  logic [((LINE_WORDS > 1) ? calc_off(LINE_WORDS)-2 : 1)-1:0] word_sel,
    input  logic [31:0]                           word_data,
    input  logic [3:0]                            word_strb,
    input  logic                                  clr_dirty
);

    localparam int LB     = 32 * LINE_WORDS;
    localparam int WSEL_W = (LINE_WORDS > 1) ? calc_off(LINE_WORDS) - 2 : 1;

    logic [LB-1:0]    data_mem [LINES];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [LB-1:0]    wr_line;

    assign line_out  = data_mem[idx];
    assign tag_out   = tag_mem[idx];
    assign valid_out = valid[idx];
    assign dirty_out = dirty[idx];

    always_comb begin
        wr_line = data_mem[idx];
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (word_sel == WSEL_W'(w) && word_strb[b]) begin
                    wr_line[w*32 + b*8 +: 8] = word_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[idx] <= fill_data;
            tag_mem[idx]  <= fill_tag;
        end else if (word_we) begin
            data_mem[idx] <= wr_line;
        end
    end

    // A store marks the line dirty even with an all-zero strobe.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_we) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (word_we) begin
            dirty[idx] <= 1'b1;
        end else if (clr_dirty) begin
            dirty[idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller with miss FSM.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int AW         = 32,
    parameter int LINES      = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [AW-1:0]            req_addr,
    input  logic [31:0]              req_wdata,
    input  logic [3:0]               req_wstrb,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_we,
    output logic [AW-1:0]            mem_req_addr,
    output logic [32*LINE_WORDS-1:0] mem_wdata,
    input  logic                     mem_rsp_valid,
    input  logic [32*LINE_WORDS-1:0] mem_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
`endif
);

    localparam int OFF_W  = calc_off(LINE_WORDS);
    localparam int IDX_W  = calc_idx(LINES);
    localparam int TAG_W  = calc_tag(AW, LINES, LINE_WORDS);
    localparam int LB     = 32 * LINE_WORDS;
    localparam int WSEL_W = (LINE_WORDS > 1) ? OFF_W - 2 : 1;

    state_t           state;
    logic             r_we;
    logic [AW-1:0]    r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic             replay;

    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_idx;
    logic [WSEL_W-1:0] word_sel;
    logic [TAG_W-1:0] line_tag;
    logic [LB-1:0]    line_data;
    logic             line_valid;
    logic             line_dirty;
    logic             hit;
    logic [31:0]      rd_word;
    logic [31:0]      merged_word;
    logic             fill_we;
    logic             word_we;
    logic             clr_dirty;
    logic             unused_addr_bits;

    assign r_tag            = r_addr[AW-1:IDX_W+OFF_W];
    assign r_idx            = r_addr[IDX_W+OFF_W-1:OFF_W];
    assign unused_addr_bits = ^r_addr[1:0];

    generate
        if (LINE_WORDS > 1) begin : g_wsel
            assign word_sel = r_addr[OFF_W-1:2];
        end else begin : g_wsel_single
            assign word_sel = '0;
        end
    endgenerate

    cache_line_store #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk       (clk),
        .rst_b     (rst_b),
        .idx       (r_idx),
        .tag_out   (line_tag),
        .line_out  (line_data),
        .valid_out (line_valid),
        .dirty_out (line_dirty),
        .fill_we   (fill_we),
        .fill_tag  (r_tag),
        .fill_data (mem_rdata),
        .word_we   (word_we),
        .word_sel  (word_sel),
        .word_data (r_wdata),
        .word_strb (r_wstrb),
        .clr_dirty (clr_dirty)
    );

    always_comb begin
        rd_word = '0;
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            if (word_sel == WSEL_W'(w)) begin
                rd_word = line_data[w*32 +: 32];
            end
        end
        merged_word = rd_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (r_wstrb[b]) begin
                merged_word[b*8 +: 8] = r_wdata[b*8 +: 8];
            end
        end
    end

    assign hit       = line_valid && (line_tag == r_tag);
    assign fill_we   = (state == FILL_WAIT) && mem_rsp_valid;
    assign word_we   = (state == TAG) && hit && r_we;
    assign clr_dirty = (state == WB) && mem_req_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state         <= IDLE;
            req_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_wdata     <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            replay        <= 1'b0;
`ifdef CACHE_STATS_EN
            hit_count     <= '0;
            miss_count    <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        r_we      <= req_we;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_wstrb   <= req_we ? req_wstrb : 4'b0000;
                        replay    <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= TAG;
                    end
                end
                TAG: begin
                    if (hit) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= r_we ? merged_word : rd_word;
                        req_ready <= 1'b1;
                        state     <= IDLE;
`ifdef CACHE_STATS_EN
                        if (!replay) begin
                            hit_count <= hit_count + 32'd1;
                        end
`endif
                    end else begin
                        mem_req_valid <= 1'b1;
`ifdef CACHE_STATS_EN
                        miss_count    <= miss_count + 32'd1;
`endif
                        if (line_valid && line_dirty) begin
                            mem_req_we   <= 1'b1;
                            mem_req_addr <= {line_tag, r_idx, {OFF_W{1'b0}}};
                            mem_wdata    <= line_data;
                            state        <= WB;
                        end else begin
                            mem_req_we   <= 1'b0;
                            mem_req_addr <= {r_tag, r_idx, {OFF_W{1'b0}}};
                            state        <= FILL_REQ;
                        end
                    end
                end
                WB: begin
                    if (mem_req_ready) begin
                        mem_req_we   <= 1'b0;
                        mem_req_addr <= {r_tag, r_idx, {OFF_W{1'b0}}};
                        state        <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    // Replay the request through TAG so the response path is shared with hits.
                    if (mem_rsp_valid) begin
                        replay <= 1'b1;
                        state  <= TAG;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Parametrised direct-mapped, write-back, write-allocate data cache with a registered CPU request/response port and a line-wide memory-side handshake. It sits between the core's load/store unit and main memory. It handles hit detection, dirty-victim writeback and line refill through its own miss state machine, with byte-granular stores. Line count, line width and address width are configurable.

## Interface
- AW, 32: byte-address width
- LINES, 256: number of lines (power of 2, ≥2)
- LINE_WORDS, 4: 32-bit words per line (power of 2, ≥1)
- Derived: OFF=log2(LINE_WORDS*4), IDX=log2(LINES), TAG=AW-IDX-OFF, LB=32*LINE_WORDS
- clk  in  1  clock
- rst_b  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU request valid
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1=store, 0=load
- req_addr  in  AW  byte address; bits [1:0] ignored
- req_wdata  in  32  store data
- req_wstrb  in  4  store byte enables
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  load data, or post-merge word for stores
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1=line writeback, 0=line read
- mem_req_addr  out  AW  line-aligned address, low OFF bits zero
- mem_wdata  out  LB  victim line
- mem_rsp_valid  in  1  refill data valid (reads only, single beat)
- mem_rdata  in  LB  refill line; word 0 in bits [31:0]

## Operation
- Address split: tag=addr[AW-1:IDX+OFF], index=addr[IDX+OFF-1:OFF], word=addr[OFF-1:2].
- FSM states:
  - IDLE: req_ready=1. On handshake, register the request and go to TAG.
  - TAG: on hit (valid & tag match), pulse rsp_valid and go to IDLE. A store merges bytes per wstrb and sets dirty. On miss, go to WB if the line is valid&dirty, otherwise go to FILL_REQ.
  - WB: mem_req_valid=1, mem_req_we=1, addr={old_tag,index,0}. On mem_req_ready, clear dirty and go to FILL_REQ.
  - FILL_REQ: mem_req_valid=1, mem_req_we=0, addr={tag,index,0}. On mem_req_ready, go to FILL_WAIT.
  - FILL_WAIT: on mem_rsp_valid, write the line, set valid, clear dirty, and go to TAG. The replay then hits.
- mem_req_* are held stable while valid&!ready. mem_rsp_valid outside FILL_WAIT is ignored.
- Reset values: valid/dirty arrays 0; state IDLE; rsp_valid 0; rsp_rdata 0; mem_req_valid 0; mem_req_we 0; mem_req_addr 0; mem_wdata 0. req_ready is 0 while rst_b is low and 1 from the first clk edge after release. The data and tag arrays are not reset.
- Reset asserted in any state aborts the in-flight transaction immediately: mem_req_valid drops and any outstanding refill is lost. The memory side is reset with the same rst_b.
- A store with wstrb=0 behaves as a load but still allocates on a miss and sets dirty.

## Timing
- Hit latency: handshake at edge N gives rsp_valid during cycle N+1. The next request is accepted at edge N+2 (peak throughput 1 per 2 cycles).
- Clean miss: responds 2 cycles after the refill beat (FILL_WAIT→TAG→rsp).
- Dirty miss adds the WB handshake, with a minimum of 1 cycle.
- rsp_rdata is valid only while rsp_valid=1.

## Configuration
- CACHE_STATS_EN defined: adds output ports hit_count[31:0] and miss_count[31:0], reset to 0.
  - hit_count increments on every TAG-state hit that is not a replay.
  - miss_count increments on every TAG-state miss.
  - Both counters wrap.
- CACHE_STATS_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package cache_pkg holds the state enum (IDLE, TAG, WB, FILL_REQ, FILL_WAIT) and the derived-width localparam functions (OFF, IDX, TAG).
- Sub-module cache_line_store holds the data, tag, valid and dirty arrays. It provides a combinational read, a line write and a strobed word write.

## Test plan
- Defaults, after reset: load 0x0000_1000 → mem read at 0x1000. Return line words {4,3,2,1} → rsp_rdata=0x1, miss_count=1.
- Then load 0x1004 → rsp_valid one cycle after the handshake, rdata=0x2, no mem_req_valid.
- Store 0x1008, wdata 0xAABBCCDD, wstrb 0011 → hit, rsp_rdata=0x0000CCDD. A following load of 0x1008 returns 0x0000CCDD.
- Load 0x0001_1000 (same index 0, tag 0x11) → mem write at 0x1000 with line {4,0x0000CCDD,2,1}, then mem read at 0x11000.
- Hold mem_req_ready low for 10 cycles during WB → mem_req_valid, addr and wdata stay stable; req_ready=0; no rsp_valid.
- Assert rst_b low in FILL_WAIT → mem_req_valid=0 and rsp_valid=0 at once. After release, load 0x1000 misses again.
